// File: rtl/mux_wd_buffered.sv
// mux_wd_buffered: write-data source selector with narrow-load extension and write-back FIFO
module mux_wd_buffered #(
    parameter int                WIDTH       = 32,
    parameter int                NSRC        = 8,
    parameter int                SEL_W       = 3,
    parameter logic [WIDTH-1:0]  DEFAULT_VAL = 227,
    parameter int                DEPTH       = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SEL_W-1:0]          sel,
    input  logic [(NSRC-1)*WIDTH-1:0] data_in,
    input  logic [1:0]                ext_mode,
    input  logic [4:0]                wr_addr,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [4:0]                out_addr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      sel_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    logic [WIDTH-1:0] sel_data, ext_data, last_data;
    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [4:0]       mem_addr [DEPTH];
    logic [4:0]       last_addr;
    logic [AW-1:0]    wptr, rptr;
    logic             sel_oob, push, store, pop;
    // source 0 and out-of-range selects fall back to the constant
    always_comb begin
        sel_data = DEFAULT_VAL;
        for (int k = 1; k < NSRC; k++)
            if (sel == SEL_W'(k)) sel_data = data_in[k*WIDTH-1 -: WIDTH];
    end
    assign ext_data = ext_mode == 2'b01 ? {{(WIDTH-16){1'b0}}, sel_data[15:0]} :
                      ext_mode == 2'b10 ? {{(WIDTH-16){sel_data[15]}}, sel_data[15:0]} :
                      ext_mode == 2'b11 ? {{(WIDTH-8){1'b0}}, sel_data[7:0]} : sel_data;
    assign sel_oob   = int'(sel) >= NSRC;
    assign in_ready  = occupancy != OW'(DEPTH);
    assign out_valid = occupancy != '0;
    assign push      = in_valid & in_ready;
    assign store     = push & (wr_addr != 5'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem_data[rptr] : last_data;
    assign out_addr  = out_valid ? mem_addr[rptr] : last_addr;
    // pointers, occupancy, last-popped hold registers and sticky select error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr      <= '0;
            rptr      <= '0;
            occupancy <= '0;
            last_data <= '0;
            last_addr <= '0;
            sel_err   <= 1'b0;
        end else begin
            if (store) wptr <= wptr + 1'b1;
            if (pop) begin
                rptr      <= rptr + 1'b1;
                last_data <= mem_data[rptr];
                last_addr <= mem_addr[rptr];
            end
            occupancy <= occupancy + OW'(store) - OW'(pop);
            if (push && sel_oob) sel_err <= 1'b1;
        end
    end
    // entry storage; contents are only observed through occupancy-qualified reads
    always_ff @(posedge clk) begin
        if (store) begin
            mem_data[wptr] <= ext_data;
            mem_addr[wptr] <= wr_addr;
        end
    end
endmodule

// File: tb/tb_mux_wd_buffered.sv
// tb_mux_wd_buffered: directed-vector bench for mux_wd_buffered (NSRC=6, DEPTH=2)
module tb_mux_wd_buffered;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  sel = '0;
    logic [159:0] data_in = '0;
    logic [1:0]  ext_mode = '0;
    logic [4:0]  wr_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic [4:0]  out_addr;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  occupancy;
    logic        sel_err;
    int nvec = 0;
    int nerr = 0;

    mux_wd_buffered #(.WIDTH(32), .NSRC(6), .SEL_W(3), .DEFAULT_VAL(32'd227), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .sel(sel), .data_in(data_in), .ext_mode(ext_mode),
        .wr_addr(wr_addr), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
        .occupancy(occupancy), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct { logic [31:0] d; logic [4:0] a; } ent_t;

    initial begin
        logic [31:0] ext_exp [4];
        ent_t q [$];
        ent_t e;
        int idx, rcv, cyc;
        logic acc, pp;
        ext_exp[0] = 32'hFFFF8001;
        ext_exp[1] = 32'h00008001;
        ext_exp[2] = 32'hFFFF8001;
        ext_exp[3] = 32'h00000001;
        data_in[31:0]  = 32'h11111111;
        data_in[63:32] = 32'hFFFF8001;
        #22;
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", out_data, 0);
        chk("rst_addr", 32'(out_addr), 0);
        chk("rst_selerr", 32'(sel_err), 0);
        chk("rst_inready", 32'(in_ready), 1);
        reset = 1'b1;
        tick();
        // constant source
        in_valid = 1; sel = 0; ext_mode = 0; wr_addr = 31; out_ready = 1;
        tick();
        in_valid = 0;
        chk("def_valid", 32'(out_valid), 1);
        chk("def_data", out_data, 227);
        chk("def_addr", 32'(out_addr), 31);
        tick();
        chk("def_empty", 32'(out_valid), 0);
        chk("def_hold", out_data, 227);
        // extension modes, back-to-back
        in_valid = 1; sel = 2; wr_addr = 4;
        for (int i = 0; i < 4; i++) begin
            ext_mode = 2'(i);
            tick();
            chk($sformatf("ext%0d_data", i), out_data, ext_exp[i]);
            chk($sformatf("ext%0d_valid", i), 32'(out_valid), 1);
        end
        in_valid = 0; ext_mode = 0;
        tick();
        chk("ext_empty", 32'(out_valid), 0);
        // backpressure
        out_ready = 0; in_valid = 1; sel = 1; wr_addr = 1;
        tick();
        chk("bp1_occ", 32'(occupancy), 1);
        wr_addr = 2;
        tick();
        chk("bp2_occ", 32'(occupancy), 2);
        chk("bp2_ready", 32'(in_ready), 0);
        wr_addr = 3;
        tick();
        chk("bp3_occ", 32'(occupancy), 2);
        chk("bp3_addr", 32'(out_addr), 1);
        out_ready = 1;
        tick();
        chk("bp4_occ", 32'(occupancy), 1);
        chk("bp4_addr", 32'(out_addr), 2);
        chk("bp4_ready", 32'(in_ready), 1);
        tick();
        chk("bp5_occ", 32'(occupancy), 1);
        chk("bp5_addr", 32'(out_addr), 3);
        chk("bp5_data", out_data, 32'h11111111);
        in_valid = 0;
        tick();
        chk("bp6_occ", 32'(occupancy), 0);
        // addr 0 discard and out-of-range select
        in_valid = 1; sel = 1; wr_addr = 0;
        tick();
        chk("a0_valid", 32'(out_valid), 0);
        chk("a0_selerr", 32'(sel_err), 0);
        sel = 7; wr_addr = 5;
        tick();
        chk("oob_data", out_data, 227);
        chk("oob_addr", 32'(out_addr), 5);
        chk("oob_selerr", 32'(sel_err), 1);
        sel = 1; wr_addr = 6;
        tick();
        chk("post_data", out_data, 32'h11111111);
        chk("post_addr", 32'(out_addr), 6);
        chk("post_selerr", 32'(sel_err), 1);
        in_valid = 0;
        tick();
        // asynchronous reset with full FIFO
        out_ready = 0; in_valid = 1; wr_addr = 7;
        tick();
        wr_addr = 8;
        tick();
        in_valid = 0;
        chk("full_occ", 32'(occupancy), 2);
        #2 reset = 0;
        #1;
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_occ", 32'(occupancy), 0);
        chk("ar_ready", 32'(in_ready), 1);
        chk("ar_data", out_data, 0);
        chk("ar_selerr", 32'(sel_err), 0);
        #3 reset = 1;
        out_ready = 1;
        tick();
        chk("ar_stale", 32'(out_valid), 0);
        // stream of 16 with toggling out_ready
        idx = 0; rcv = 0; cyc = 0;
        while ((idx < 16 || q.size() != 0) && cyc < 100) begin
            in_valid = idx < 16;
            sel = 1;
            wr_addr = 5'(idx + 1);
            data_in[31:0] = 32'(idx + 1) * 32'h01010101;
            out_ready = cyc[0];
            #1;
            chk("st_ready", 32'(in_ready), 32'(q.size() != 2));
            chk("st_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("st_data", out_data, q[0].d);
                chk("st_addr", 32'(out_addr), 32'(q[0].a));
            end
            acc = in_valid && q.size() != 2;
            pp = out_ready && q.size() != 0;
            e.d = 32'(idx + 1) * 32'h01010101;
            e.a = 5'(idx + 1);
            if (pp) begin
                void'(q.pop_front());
                rcv++;
            end
            if (acc) begin
                q.push_back(e);
                idx++;
            end
            tick();
            cyc++;
        end
        in_valid = 0;
        chk("st_count", 32'(rcv), 16);
        chk("st_occ", 32'(occupancy), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
